// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: scans a 4x4 hex keypad one row at a time, synchronizes the
// column inputs, debounces press and release, and emits one registered key code
// per press. digit_new/digit_old hold the last two accepted keys.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held).
module keypad_scan_fsm #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_CYCLES   = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    // One shared width, large enough that no counter can wrap while in use.
    localparam int MAX_AB  = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_CNT = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t SCAN_LAST = cnt_t'(SCAN_DIV - 1);
    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state, state_d;
    logic [1:0] row_idx, row_d;
    logic [1:0] cap_r, cap_r_d;
    logic [1:0] cap_c, cap_c_d;
    cnt_t       dwell, dwell_d;
    cnt_t       deb_cnt, deb_d;
`ifdef KEYPAD_REPEAT_EN
    cnt_t       rep_cnt, rep_d;
`endif
    logic       fire;

    logic [3:0] col_s1;
    logic [3:0] cs;
    logic       cs_hit;
    logic [1:0] cs_idx;
    logic [3:0] key_code;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (!reset) begin
            col_s1 <= '0;
            cs     <= '0;
        end else begin
            col_s1 <= col;
            cs     <= col_s1;
        end
    end

    // State register plus all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            cap_r     <= 2'd0;
            cap_c     <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
            key       <= 4'h0;
            key_valid <= 1'b0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            state     <= state_d;
            row_idx   <= row_d;
            cap_r     <= cap_r_d;
            cap_c     <= cap_c_d;
            dwell     <= dwell_d;
            deb_cnt   <= deb_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_d;
`endif
            key_valid <= fire;
            if (fire) begin
                key       <= key_code;
                digit_old <= digit_new;
                digit_new <= key_code;
            end
        end
    end

    // Next-state logic: scan dwell, capture, debounce, hold and release tracking.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        state_d = state;
        row_d   = row_idx;
        cap_r_d = cap_r;
        cap_c_d = cap_c;
        dwell_d = dwell;
        deb_d   = deb_cnt;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_cnt;
`endif
        fire    = 1'b0;

        cs_hit = cs[cap_c];
        cs_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cs[i]) cs_idx = 2'(i);
        end

        unique case (state)
            SCAN: begin
                if (dwell == SCAN_LAST) begin
                    dwell_d = '0;
                    if ($onehot(cs)) begin
                        // Exactly one column on the driven row: lock onto it.
                        cap_r_d = row_idx;
                        cap_c_d = cs_idx;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_idx + 2'd1;
                    end
                end else begin
                    dwell_d = dwell + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (!cs_hit) begin
                    state_d = SCAN;
                    row_d   = row_idx + 2'd1;
                    dwell_d = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d = HELD;
                    fire    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    deb_d = deb_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!cs_hit) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    fire  = 1'b1;
                    rep_d = '0;
                end else begin
                    rep_d = rep_cnt + CNT_ONE;
                end
`endif
            end
            RELEASE: begin
                if (cs_hit) begin
                    // Release glitch: back to holding, no new pulse.
                    state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_d   = '0;
`endif
                end else if (deb_cnt == DEB_LAST) begin
                    state_d = SCAN;
                    row_d   = row_idx + 2'd1;
                    dwell_d = '0;
                end else begin
                    deb_d = deb_cnt + CNT_ONE;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Output decode: one-hot row drive and key map lookup of the captured position.
    always_comb begin
        row = 4'b0001 << row_idx;
        case ({cap_r, cap_c})
            4'b00_00: key_code = 4'h1;
            4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;
            4'b00_11: key_code = 4'hA;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b01_11: key_code = 4'hB;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'hE;
            4'b11_01: key_code = 4'h0;
            4'b11_10: key_code = 4'hF;
            default:  key_code = 4'hD;
        endcase
    end

endmodule
